// File: rtl/ss_pkg.sv
// Shared definitions for the save-state sequencer: state encoding, address width
// and transfer direction constants.
package ss_pkg;

    localparam int SS_LEN_DEF = 128;
    localparam int SS_AW      = 8;

    localparam logic SS_SAVE = 1'b0;
    localparam logic SS_LOAD = 1'b1;

    typedef enum logic [2:0] {
        SS_IDLE    = 3'd0,
        SS_SV_ADDR = 3'd1,
        SS_SV_PUSH = 3'd2,
        SS_RS_PULL = 3'd3,
        SS_RS_ARM  = 3'd4,
        SS_RS_WR   = 3'd5,
        SS_SUM     = 3'd6,
        SS_FIN     = 3'd7
    } ss_state_e;

endpackage

// File: rtl/map_ss_seq_m2_sync.sv
// Brings the cartridge M2 pin into the clk domain and emits registered one-clk
// rise/fall pulses, three clk behind the pin.
module m2_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic m2_i,
    output logic rise_o,
    output logic fall_o
);

    logic [2:0] sync_q;
    logic       rise_q;
    logic       fall_q;

    // sync_q[1:0] is the metastability chain; sync_q[2] holds the previous sample.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], m2_i};
            rise_q <= sync_q[1] & ~sync_q[2];
            fall_q <= ~sync_q[1] & sync_q[2];
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/map_ss_seq.sv
// Save-state sequencer: streams mapper state out to the host (save) or back in,
// one write per M2 falling edge (restore). Define SS_SUM_EN to add a checksum byte.
module map_ss_seq
    import ss_pkg::*;
#(
    parameter int SS_LEN = SS_LEN_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             m2,
    input  logic             start,
    input  logic             mode,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [7:0]       tx_dat,
    output logic             tx_vld,
    input  logic             tx_rdy,
    input  logic [7:0]       rx_dat,
    input  logic             rx_vld,
    output logic             rx_rdy,
    output logic             ss_act,
    output logic             ss_we,
    output logic [SS_AW-1:0] ss_addr,
    output logic [7:0]       ss_wdat,
    input  logic [7:0]       ss_rdat,
    output ss_state_e        dbg_state_o
);

    // Nine address bits so SS_LEN=256 reaches its last address without wrapping.
    localparam logic [SS_AW:0] LAST = (SS_AW+1)'(SS_LEN - 1);

    ss_state_e      state_q, state_d;
    logic [SS_AW:0] addr_q, addr_d;
    logic [7:0]     tx_q, tx_d;
    logic [7:0]     wdat_q, wdat_d;
    logic           we_q, we_d;
    logic           err_q, err_d;
    logic           done_q, done_d;
    logic           m2_rise, m2_fall;
    logic           last;
`ifdef SS_SUM_EN
    logic [7:0]     sum_q, sum_d;
    logic           mode_q, mode_d;
`endif

    m2_sync u_m2_sync (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .m2_i   (m2),
        .rise_o (m2_rise),
        .fall_o (m2_fall)
    );

    assign last = (addr_q == LAST);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        tx_d    = tx_q;
        wdat_d  = wdat_q;
        we_d    = we_q;
        err_d   = err_q;
        done_d  = 1'b0;
`ifdef SS_SUM_EN
        sum_d   = sum_q;
        mode_d  = mode_q;
`endif
        case (state_q)
            SS_IDLE: if (start) begin
                state_d = (mode == SS_LOAD) ? SS_RS_PULL : SS_SV_ADDR;
                addr_d  = '0;
                err_d   = 1'b0;
`ifdef SS_SUM_EN
                sum_d   = '0;
                mode_d  = mode;
`endif
            end
            SS_SV_ADDR: begin
                tx_d    = ss_rdat;
                state_d = SS_SV_PUSH;
            end
            SS_SV_PUSH: if (tx_rdy) begin
`ifdef SS_SUM_EN
                sum_d = sum_q + tx_q;
`endif
                if (last) begin
`ifdef SS_SUM_EN
                    tx_d    = sum_q + tx_q;
                    state_d = SS_SUM;
`else
                    state_d = SS_FIN;
`endif
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = SS_SV_ADDR;
                end
            end
            SS_RS_PULL: if (rx_vld) begin
                wdat_d  = rx_dat;
`ifdef SS_SUM_EN
                sum_d   = sum_q + rx_dat;
`endif
                state_d = SS_RS_ARM;
            end
            // Waiting for a rise guarantees a full M2-high phase before the latching fall.
            SS_RS_ARM: if (m2_rise) begin
                we_d    = 1'b1;
                state_d = SS_RS_WR;
            end
            SS_RS_WR: if (m2_fall) begin
                we_d = 1'b0;
                if (last) begin
`ifdef SS_SUM_EN
                    state_d = SS_SUM;
`else
                    state_d = SS_FIN;
`endif
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = SS_RS_PULL;
                end
            end
            SS_SUM: begin
`ifdef SS_SUM_EN
                if (mode_q == SS_SAVE) begin
                    if (tx_rdy) state_d = SS_FIN;
                end else if (rx_vld) begin
                    if (rx_dat != sum_q) err_d = 1'b1;
                    state_d = SS_FIN;
                end
`else
                state_d = SS_IDLE;
`endif
            end
            SS_FIN:  state_d = SS_IDLE;
            default: state_d = SS_IDLE;
        endcase

        if (state_d == SS_FIN) done_d = 1'b1;

        if (abort && (state_q != SS_IDLE)) begin
            state_d = SS_IDLE;
            we_d    = 1'b0;
            err_d   = 1'b1;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SS_IDLE;
            addr_q  <= '0;
            tx_q    <= '0;
            wdat_q  <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            tx_q    <= tx_d;
            wdat_q  <= wdat_d;
            we_q    <= we_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

`ifdef SS_SUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            mode_q <= SS_SAVE;
        end else begin
            sum_q  <= sum_d;
            mode_q <= mode_d;
        end
    end

    assign tx_vld = (state_q == SS_SV_PUSH) || ((state_q == SS_SUM) && (mode_q == SS_SAVE));
    assign rx_rdy = (state_q == SS_RS_PULL) || ((state_q == SS_SUM) && (mode_q == SS_LOAD));
`else
    assign tx_vld = (state_q == SS_SV_PUSH);
    assign rx_rdy = (state_q == SS_RS_PULL);
`endif

    assign busy        = (state_q != SS_IDLE) && (state_q != SS_FIN);
    assign ss_act      = (state_q != SS_IDLE) && (state_q != SS_FIN);
    assign done        = done_q;
    assign err         = err_q;
    assign tx_dat      = tx_q;
    assign ss_we       = we_q;
    assign ss_addr     = addr_q[SS_AW-1:0];
    assign ss_wdat     = wdat_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_map_ss_seq.sv
// Scoreboarded bench for map_ss_seq: queued expectations for the tx stream and
// mapper writes, popped by independent monitors.
`timescale 1ns/1ps
module tb_map_ss_seq;
    import ss_pkg::*;

    localparam int N = 128;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic m2 = 1'b0;
    logic start = 1'b0, mode = 1'b0, abort = 1'b0;
    logic tx_rdy = 1'b0, rx_vld = 1'b0;
    logic [7:0] rx_dat = 8'h00;
    logic [7:0] ss_rdat;
    logic busy, done, err, tx_vld, rx_rdy, ss_act, ss_we;
    logic [7:0] tx_dat, ss_addr, ss_wdat;
    ss_state_e dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  mem [256];
    logic [7:0]  exp_q[$];
    logic [15:0] exp_wr_q[$];
    logic [3:0]  prg = 4'h0, chr = 4'h0;
    int  we_pulses = 0, falls_in_we = 0, rdy_mode = 0, rdy_cnt = 0;
    bit  we_chk_en = 1'b1, stop_rx = 1'b0, hit = 1'b0, ok_a = 1'b0;

    map_ss_seq #(.SS_LEN(N)) dut (
        .clk(clk), .rst_n(rst_n), .m2(m2), .start(start), .mode(mode), .abort(abort),
        .busy(busy), .done(done), .err(err),
        .tx_dat(tx_dat), .tx_vld(tx_vld), .tx_rdy(tx_rdy),
        .rx_dat(rx_dat), .rx_vld(rx_vld), .rx_rdy(rx_rdy),
        .ss_act(ss_act), .ss_we(ss_we), .ss_addr(ss_addr), .ss_wdat(ss_wdat),
        .ss_rdat(ss_rdat), .dbg_state_o(dbg_state)
    );

    // Clock / M2 generation: M2 edges land at 2 mod 10 ns, clear of every clk edge.
    always #5 clk = ~clk;
    initial begin
        #2;
        forever #280 m2 = ~m2;
    end

    assign ss_rdat = mem[ss_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // tx_rdy pattern: 0 = always ready, 1 = toggles every 3 clk, 2 = random.
    always @(posedge clk) begin
        #1;
        rdy_cnt++;
        case (rdy_mode)
            0:       tx_rdy = 1'b1;
            1:       if (rdy_cnt % 3 == 0) tx_rdy = ~tx_rdy;
            default: tx_rdy = 1'($urandom_range(0, 1));
        endcase
    end

    // Save-stream monitor.
    logic       prev_stall = 1'b0;
    logic [7:0] prev_dat = 8'h00;
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall && tx_vld) check("tx_stable_in_stall", tx_dat, prev_dat);
            if (tx_vld && tx_rdy) begin
                if (exp_q.size() == 0) check("tx_queue_nonempty", exp_q.size(), 1);
                else check("tx_byte", tx_dat, exp_q.pop_front());
            end
            prev_stall = tx_vld && !tx_rdy;
            prev_dat   = tx_dat;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Mapper model: latches on the M2 falling edge while ss_we is asserted.
    always @(negedge m2) begin
        if (ss_act && ss_we) begin
            falls_in_we++;
            if (exp_wr_q.size() == 0) check("wr_queue_nonempty", exp_wr_q.size(), 1);
            else check("ss_write_addr_data", {ss_addr, ss_wdat}, exp_wr_q.pop_front());
            if (ss_addr == 8'd0) begin
                prg = ss_wdat[3:0];
                chr = ss_wdat[7:4];
            end
        end
    end

    logic prev_we = 1'b0;
    always @(negedge clk) begin
        if (ss_we && !prev_we) begin
            we_pulses++;
            falls_in_we = 0;
        end
        if (!ss_we && prev_we && we_chk_en) check("we_spans_one_m2_fall", falls_in_we, 1);
        prev_we = ss_we;
    end

    // Driver tasks.
    task automatic do_start(input logic m);
        @(negedge clk);
        mode  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen, output logic err_at);
        seen   = 1'b0;
        err_at = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen   = 1'b1;
                err_at = err;
            end
        end
    endtask

    task automatic send_rx(input logic [7:0] b, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        rx_dat = b;
        rx_vld = 1'b1;
        for (int i = 0; i < 2000 && !ok && !stop_rx; i++) begin
            if (rx_rdy) ok = 1'b1;
            else @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end
        rx_vld = 1'b0;
    endtask

    task automatic run_save(input int rm, input bit busy_start);
        int   s;
        bit   seen;
        logic e;
        s = 0;
        for (int i = 0; i < N; i++) begin
            exp_q.push_back(mem[i]);
            s += int'(mem[i]);
        end
`ifdef SS_SUM_EN
        exp_q.push_back(8'(s));
`endif
        rdy_mode = rm;
        do_start(SS_SAVE);
        check("err_cleared_on_start", err, 1'b0);
        check("busy_after_start", busy, 1'b1);
        if (busy_start) do_start(SS_LOAD);
        wait_done(5000, seen, e);
        check("save_done_seen", seen, 1'b1);
        check("save_err", e, 1'b0);
        check("save_bytes_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic run_restore(input bit corrupt);
        int   s, sent;
        bit   ok, seen;
        logic e;
        s = 0;
        sent = 0;
        we_pulses = 0;
        for (int i = 0; i < N; i++) begin
            exp_wr_q.push_back({8'(i), mem[i]});
            s += int'(mem[i]);
        end
        do_start(SS_LOAD);
        for (int i = 0; i < N; i++) begin
            send_rx(mem[i], ok);
            if (ok) sent++;
        end
`ifdef SS_SUM_EN
        send_rx(corrupt ? ~8'(s) : 8'(s), ok);
        if (ok) sent++;
        check("restore_bytes_accepted", sent, N + 1);
`else
        check("restore_bytes_accepted", sent, N);
`endif
        wait_done(3000, seen, e);
        check("restore_done_seen", seen, 1'b1);
        check("restore_err", e, corrupt);
        repeat (200) @(negedge clk);
        check("restore_we_pulses", we_pulses, N);
        check("restore_writes_left", exp_wr_q.size(), 0);
        check("mapper_prg", prg, mem[0][3:0]);
        check("mapper_chr", chr, mem[0][7:4]);
        exp_wr_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},    busy, 1'b0);
        check({tag, "_done"},    done, 1'b0);
        check({tag, "_err"},     err, 1'b0);
        check({tag, "_tx_vld"},  tx_vld, 1'b0);
        check({tag, "_tx_dat"},  tx_dat, 8'h00);
        check({tag, "_rx_rdy"},  rx_rdy, 1'b0);
        check({tag, "_ss_act"},  ss_act, 1'b0);
        check({tag, "_ss_we"},   ss_we, 1'b0);
        check({tag, "_ss_addr"}, ss_addr, 8'h00);
        check({tag, "_ss_wdat"}, ss_wdat, 8'h00);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   seen;
        logic e;
        for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
        mem[0]   = 8'hA5;
        mem[N-1] = 8'h4D;

        // Reset block.
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        check("reset_state", 32'(dbg_state), 32'(SS_IDLE));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Save: fixed pattern, always ready, then throttled with a start while busy.
        run_save(0, 1'b0);
        run_save(1, 1'b1);

        // Save: random contents, random backpressure.
        for (int i = 0; i < N; i++) mem[i] = 8'($urandom_range(0, 255));
        run_save(2, 1'b0);

        // Restore with byte 0 = 0x3C.
        for (int i = 0; i < N; i++) mem[i] = 8'($urandom_range(0, 255));
        mem[0] = 8'h3C;
        run_restore(1'b0);
        check("mapper_prg_3c", prg, 4'hC);
        check("mapper_chr_3c", chr, 4'h3);
`ifdef SS_SUM_EN
        for (int i = 0; i < N; i++) mem[i] = 8'($urandom_range(0, 255));
        run_restore(1'b1);
`endif

        // Abort during the write of address 40.
        for (int i = 0; i < N; i++) begin
            mem[i] = 8'($urandom_range(0, 255));
            exp_wr_q.push_back({8'(i), mem[i]});
        end
        stop_rx = 1'b0;
        hit     = 1'b0;
        do_start(SS_LOAD);
        fork
            begin
                for (int i = 0; i < N && !stop_rx; i++) send_rx(mem[i], ok_a);
            end
            begin
                for (int c = 0; c < 20000 && !hit; c++) begin
                    @(negedge clk);
                    if (ss_we && ss_addr == 8'd40) hit = 1'b1;
                end
                check("abort_reached_addr40", hit, 1'b1);
                we_chk_en = 1'b0;
                abort     = 1'b1;
                stop_rx   = 1'b1;
                @(posedge clk);
                #1;
                check("abort_ss_we", ss_we, 1'b0);
                check("abort_ss_act", ss_act, 1'b0);
                check("abort_err", err, 1'b1);
                check("abort_done", done, 1'b1);
                check("abort_busy", busy, 1'b0);
                check("abort_state", 32'(dbg_state), 32'(SS_IDLE));
                abort = 1'b0;
                @(negedge clk);
                #1 we_chk_en = 1'b1;
            end
        join
        check("abort_writes_left", exp_wr_q.size(), N - 40);
        exp_wr_q.delete();
        run_save(0, 1'b0);

        // Asynchronous reset mid-save at address 10.
        for (int i = 0; i < N; i++) exp_q.push_back(mem[i]);
        rdy_mode = 0;
        hit      = 1'b0;
        do_start(SS_SAVE);
        for (int c = 0; c < 2000 && !hit; c++) begin
            @(negedge clk);
            if (ss_addr == 8'd10) hit = 1'b1;
        end
        check("reset_reached_addr10", hit, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) mem[i] = 8'($urandom_range(0, 255));
        run_save(2, 1'b0);

        wait_done(20, seen, e);
        check("no_spurious_done", seen, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
